// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the single-MAC FIR controller.
// State encoding, default sizes and a modulo-N pointer helper.
package fir_ctrl_pkg;

  localparam int N_TAPS_DEF = 123;
  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 16;

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  function automatic int circ_next(
    input int   cur,
    input logic up,
    input int   n
  );
    if (up)
      return (cur == n - 1) ? 0 : cur + 1;
    return (cur == 0) ? n - 1 : cur - 1;
  endfunction

endpackage

// File: rtl/fir_circ_addr.sv
// Loadable modulo-N pointer that steps up or down with wrap.
// Holds its value when neither load nor step is asserted.
module fir_circ_addr
  import fir_ctrl_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic         up,
  output logic [W-1:0] val
);

  always_ff @(posedge clk) begin
    if (!rst)
      val <= '0;
    else if (load)
      val <= load_val;
    else if (step)
      val <= W'(circ_next(int'(val), up, N));
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequencer for a time-multiplexed single-MAC FIR filter.
// Writes samples to a circular RAM and walks all taps through the MAC.
module fir_mac_sequencer
  import fir_ctrl_pkg::*;
#(
  parameter int N_TAPS = N_TAPS_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              out_valid,
  output logic              busy
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] INIT_END = CNT_W'(N_TAPS);
  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(N_TAPS - 1);

  logic [2:0]        state;
  logic [CNT_W-1:0]  init_cnt;
  logic [ADDR_W-1:0] head;
  logic              last_tap;
  logic              ra_load;
  logic              ra_step;
  logic              head_step;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign last_tap  = (coef_addr == K_LAST);
  assign ra_load   = (state == S_WRITE);
  assign ra_step   = (state == S_RUN) && !last_tap;
  assign head_step = (state == S_DONE);

  // rd_addr walks backwards from head: x[n], x[n-1], ...
  fir_circ_addr #(.N(N_TAPS), .W(ADDR_W)) u_ra (
    .clk      (clk),
    .rst      (rst),
    .load     (ra_load),
    .load_val (head),
    .step     (ra_step),
    .up       (1'b0),
    .val      (rd_addr)
  );

  fir_circ_addr #(.N(N_TAPS), .W(ADDR_W)) u_head (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val ('0),
    .step     (head_step),
    .up       (1'b1),
    .val      (head)
  );

  // Strobes are registered so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_INIT;
      init_cnt  <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      coef_addr <= '0;
      mac_en    <= 1'b0;
      mac_clr   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      mac_en    <= (state == S_RUN);
      mac_clr   <= (state == S_RUN) && (coef_addr == '0);
      out_valid <= (state == S_DRAIN);
      unique case (state)
        S_INIT: begin
          if (init_cnt == INIT_END) begin
            state <= S_IDLE;
          end else begin
            wr_en    <= 1'b1;
            wr_addr  <= init_cnt[ADDR_W-1:0];
            wr_data  <= '0;
            init_cnt <= init_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (in_valid) begin
            state   <= S_WRITE;
            wr_en   <= 1'b1;
            wr_addr <= head;
            wr_data <= in_data;
          end
        end
        S_WRITE: begin
          state     <= S_RUN;
          coef_addr <= '0;
        end
        S_RUN: begin
          if (last_tap)
            state <= S_DRAIN;
          else
            coef_addr <= coef_addr + 1'b1;
        end
        S_DRAIN: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: 4-tap and 123-tap instances with
// RAM/ROM/MAC models and a convolution scoreboard.
module tb_fir_mac_sequencer;

  typedef struct {
    longint y;
    int     cyc;
  } exp_t;

  typedef struct {
    int         off;
    logic       we;
    logic [1:0] wa;
    int         wd;
    logic       rchk;
    logic [1:0] ra;
    logic [1:0] ca;
    logic       me;
    logic       mc;
    logic       ov;
    logic       rdy;
  } row_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // 4-tap instance
  logic              rst4;
  logic              in_valid4;
  logic              in_ready4;
  logic signed [15:0] in_data4;
  logic              wr_en4;
  logic [1:0]        wr_addr4;
  logic [15:0]       wr_data4;
  logic [1:0]        rd_addr4;
  logic [1:0]        coef_addr4;
  logic              mac_clr4;
  logic              mac_en4;
  logic              out_valid4;
  logic              busy4;

  fir_mac_sequencer #(.N_TAPS(4), .ADDR_W(2), .DATA_W(16)) dut4 (
    .clk       (clk),
    .rst       (rst4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .in_data   (in_data4),
    .wr_en     (wr_en4),
    .wr_addr   (wr_addr4),
    .wr_data   (wr_data4),
    .rd_addr   (rd_addr4),
    .coef_addr (coef_addr4),
    .mac_clr   (mac_clr4),
    .mac_en    (mac_en4),
    .out_valid (out_valid4),
    .busy      (busy4)
  );

  // 123-tap instance with default parameters
  logic              rst123;
  logic              in_valid123;
  logic              in_ready123;
  logic signed [15:0] in_data123;
  logic              wr_en123;
  logic [6:0]        wr_addr123;
  logic [15:0]       wr_data123;
  logic [6:0]        rd_addr123;
  logic [6:0]        coef_addr123;
  logic              mac_clr123;
  logic              mac_en123;
  logic              out_valid123;
  logic              busy123;

  fir_mac_sequencer dut123 (
    .clk       (clk),
    .rst       (rst123),
    .in_valid  (in_valid123),
    .in_ready  (in_ready123),
    .in_data   (in_data123),
    .wr_en     (wr_en123),
    .wr_addr   (wr_addr123),
    .wr_data   (wr_data123),
    .rd_addr   (rd_addr123),
    .coef_addr (coef_addr123),
    .mac_clr   (mac_clr123),
    .mac_en    (mac_en123),
    .out_valid (out_valid123),
    .busy      (busy123)
  );

  // External datapath models
  int c4 [4];
  int c123 [123];

  logic signed [15:0] ram4 [4];
  logic signed [15:0] rq4;
  int                 cq4;
  longint             acc4;

  always @(posedge clk) begin
    if (wr_en4) ram4[wr_addr4] <= wr_data4;
    rq4 <= ram4[rd_addr4];
    cq4 <= c4[coef_addr4];
    if (mac_en4)
      acc4 <= (mac_clr4 ? 64'sd0 : acc4) + longint'(rq4) * longint'(cq4);
  end

  logic signed [15:0] ram123 [128];
  logic signed [15:0] rq123;
  int                 cq123;
  longint             acc123;

  always @(posedge clk) begin
    if (wr_en123) ram123[wr_addr123] <= wr_data123;
    rq123 <= ram123[rd_addr123];
    cq123 <= (coef_addr123 < 7'd123) ? c123[coef_addr123] : 32'h7fff_ffff;
    if (mac_en123)
      acc123 <= (mac_clr123 ? 64'sd0 : acc123) + longint'(rq123) * longint'(cq123);
  end

  // Scoreboards
  exp_t   q4[$];
  exp_t   q123[$];
  longint hist4[$];
  longint hist123[$];
  int     nacc4 = 0;
  int     out_cnt123 = 0;

  function automatic longint conv4();
    longint s = 0;
    int n = hist4.size();
    for (int k = 0; k < 4; k++)
      if (k < n) s += longint'(c4[k]) * hist4[n-1-k];
    return s;
  endfunction

  function automatic longint conv123();
    longint s = 0;
    int n = hist123.size();
    for (int k = 0; k < 123; k++)
      if (k < n) s += longint'(c123[k]) * hist123[n-1-k];
    return s;
  endfunction

  always @(negedge clk) begin : sb4
    exp_t e;
    if (rst4 && out_valid4) begin
      total++;
      if (q4.size() == 0) begin
        bad++;
        $display("FAIL sb4 unexpected out_valid acc=%0d", acc4);
      end else begin
        e = q4.pop_front();
        if (acc4 != e.y || cyc - e.cyc != 7) begin
          bad++;
          $display("FAIL sb4 y=%0d lat=%0d want y=%0d lat=7",
                   acc4, cyc - e.cyc, e.y);
        end
      end
    end
  end

  always @(negedge clk) begin : sb123
    exp_t e;
    if (rst123 && out_valid123) begin
      total++;
      out_cnt123++;
      if (q123.size() == 0) begin
        bad++;
        $display("FAIL sb123 unexpected out_valid acc=%0d", acc123);
      end else begin
        e = q123.pop_front();
        if (acc123 != e.y || cyc - e.cyc != 126) begin
          bad++;
          $display("FAIL sb123 y=%0d lat=%0d want y=%0d lat=126",
                   acc123, cyc - e.cyc, e.y);
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic wait_rdy4();
    for (int i = 0; i < 300 && !in_ready4; i++) @(negedge clk);
    if (!in_ready4) chk("wait_rdy4_timeout", 0, 1);
  endtask

  task automatic wait_rdy123();
    for (int i = 0; i < 400 && !in_ready123; i++) @(negedge clk);
    if (!in_ready123) chk("wait_rdy123_timeout", 0, 1);
  endtask

  // Leaves the caller at the negedge of T+1
  task automatic send4(input logic signed [15:0] d, output int h, output int tc);
    wait_rdy4();
    h = nacc4 % 4;
    tc = cyc;
    in_valid4 = 1'b1;
    in_data4 = d;
    hist4.push_back(longint'(d));
    nacc4++;
    q4.push_back('{conv4(), cyc});
    @(negedge clk);
    in_valid4 = 1'b0;
  endtask

  task automatic check_write4(input int h, input logic signed [15:0] d);
    chk("wr_en", longint'(wr_en4), 1);
    chk("wr_addr", longint'(wr_addr4), h);
    chk("wr_data", longint'(wr_data4), longint'(d) & 16'hffff);
  endtask

  task automatic check_run4(input int h);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("run_rd_addr", longint'(rd_addr4), (h - k + 4) % 4);
      chk("run_coef_addr", longint'(coef_addr4), k);
    end
  endtask

  task automatic drain4();
    for (int i = 0; i < 200 && q4.size() != 0; i++) @(negedge clk);
    chk("drain4_pending", q4.size(), 0);
  endtask

  task automatic pulse_rst4();
    rst4 = 1'b0;
    repeat (2) @(negedge clk);
    q4.delete();
    hist4.delete();
    nacc4 = 0;
    rst4 = 1'b1;
  endtask

  row_t rows [8];
  int   h;
  int   tc;
  int   prev;
  int   n;
  int   wcnt;
  int   ovcnt;

  initial begin
    c4 = '{3, -5, 7, 2};
    for (int i = 0; i < 123; i++) c123[i] = ((i * 37) % 201) - 100;

    rows[0] = '{1, 1, 0, 100, 0, 0, 0, 0, 0, 0, 0};
    rows[1] = '{2, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0};
    rows[2] = '{3, 0, 0, 0,   1, 3, 1, 1, 1, 0, 0};
    rows[3] = '{4, 0, 0, 0,   1, 2, 2, 1, 0, 0, 0};
    rows[4] = '{5, 0, 0, 0,   1, 1, 3, 1, 0, 0, 0};
    rows[5] = '{6, 0, 0, 0,   1, 1, 3, 1, 0, 0, 0};
    rows[6] = '{7, 0, 0, 0,   1, 1, 3, 0, 0, 1, 0};
    rows[7] = '{8, 0, 0, 0,   1, 1, 3, 0, 0, 0, 1};

    rst4 = 1'b0;
    rst123 = 1'b0;
    in_valid4 = 1'b0;
    in_data4 = '0;
    in_valid123 = 1'b0;
    in_data123 = '0;
    repeat (2) @(negedge clk);

    chk("rst_wr_en", longint'(wr_en4), 0);
    chk("rst_addrs", longint'({wr_addr4, rd_addr4, coef_addr4}), 0);
    chk("rst_wr_data", longint'(wr_data4), 0);
    chk("rst_strobes", longint'({mac_en4, mac_clr4, out_valid4, in_ready4}), 0);
    chk("rst_busy", longint'(busy4), 1);
    rst4 = 1'b1;
    rst123 = 1'b1;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("init_wr_en", longint'(wr_en4), 1);
      chk("init_wr_addr", longint'(wr_addr4), i);
      chk("init_wr_data", longint'(wr_data4), 0);
      chk("init_ready", longint'({in_ready4, busy4}), 1);
    end
    @(negedge clk);
    chk("idle_ready", longint'(in_ready4), 1);
    chk("idle_busy", longint'(busy4), 0);
    chk("idle_wr_en", longint'(wr_en4), 0);

    // single sample, table driven
    send4(16'sd100, h, tc);
    foreach (rows[i]) begin
      if (rows[i].off > 1) @(negedge clk);
      chk("tbl_wr_en", longint'(wr_en4), longint'(rows[i].we));
      if (rows[i].we) begin
        chk("tbl_wr_addr", longint'(wr_addr4), longint'(rows[i].wa));
        chk("tbl_wr_data", longint'(wr_data4), rows[i].wd);
      end
      if (rows[i].rchk) begin
        chk("tbl_rd_addr", longint'(rd_addr4), longint'(rows[i].ra));
        chk("tbl_coef_addr", longint'(coef_addr4), longint'(rows[i].ca));
      end
      chk("tbl_mac_en", longint'(mac_en4), longint'(rows[i].me));
      chk("tbl_mac_clr", longint'(mac_clr4), longint'(rows[i].mc));
      chk("tbl_out_valid", longint'(out_valid4), longint'(rows[i].ov));
      chk("tbl_in_ready", longint'(in_ready4), longint'(rows[i].rdy));
      chk("tbl_busy", longint'(busy4), longint'(!rows[i].rdy));
    end
    drain4();

    // five back-to-back samples from a fresh head
    pulse_rst4();
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      logic signed [15:0] d;
      d = 16'(11 * (i + 1) - 40);
      send4(d, h, tc);
      chk("b2b_head", h, i % 4);
      check_write4(i % 4, d);
      check_run4(i % 4);
      if (i > 0) chk("b2b_spacing", tc - prev, 8);
      prev = tc;
    end
    drain4();

    // in_valid held high
    in_valid4 = 1'b1;
    in_data4 = 16'sd200;
    n = 0;
    prev = 0;
    for (int t = 0; t < 80 && n < 4; t++) begin
      if (in_ready4) begin
        hist4.push_back(longint'(in_data4));
        nacc4++;
        q4.push_back('{conv4(), cyc});
        if (n > 0) chk("held_spacing", cyc - prev, 8);
        prev = cyc;
        n++;
        @(negedge clk);
        in_data4 = 16'(200 + n * 13);
      end else begin
        @(negedge clk);
      end
    end
    in_valid4 = 1'b0;
    chk("held_accepts", n, 4);
    drain4();

    // reset in the middle of RUN
    send4(16'sd77, h, tc);
    chk("abort_head", h, 1);
    check_write4(h, 16'sd77);
    repeat (2) @(negedge clk);
    rst4 = 1'b0;
    @(negedge clk);
    chk("abort_strobes",
        longint'({wr_en4, mac_en4, mac_clr4, out_valid4, in_ready4}), 0);
    chk("abort_busy", longint'(busy4), 1);
    chk("abort_addrs", longint'({rd_addr4, coef_addr4}), 0);
    q4.delete();
    hist4.delete();
    nacc4 = 0;
    rst4 = 1'b1;
    wcnt = 0;
    ovcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid4) ovcnt++;
      if (wr_en4) begin
        chk("abort_init_addr", longint'(wr_addr4), wcnt);
        wcnt++;
      end
    end
    chk("abort_no_out_valid", ovcnt, 0);
    chk("abort_init_writes", wcnt, 4);
    send4(16'sd55, h, tc);
    check_write4(0, 16'sd55);
    check_run4(0);
    drain4();

    // 123 taps: impulse response
    for (int i = 0; i < 123; i++) begin
      logic signed [15:0] d;
      d = (i == 0) ? 16'sd1 : 16'sd0;
      wait_rdy123();
      in_valid123 = 1'b1;
      in_data123 = d;
      hist123.push_back(longint'(d));
      q123.push_back('{conv123(), cyc});
      @(negedge clk);
      in_valid123 = 1'b0;
    end
    for (int i = 0; i < 400 && q123.size() != 0; i++) @(negedge clk);
    chk("drain123_pending", q123.size(), 0);
    chk("out_cnt123", out_cnt123, 123);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Controller for a time-multiplexed, single-MAC FIR filter.
- Accepts one input sample per transaction on a valid/ready handshake and writes it into an external circular sample RAM.
- Steps the sample RAM and coefficient ROM read addresses through all taps and drives MAC clear/enable strobes, then flags when the result is ready.
- Sits between the sample source and the shared RAM/ROM/MAC datapath, replacing the fully parallel tapped-delay-line filter when area matters more than throughput.

Parameters:
- N_TAPS, 123, number of filter taps; also the depth of the circular sample buffer.
- ADDR_W, 7, address width; must satisfy 2**ADDR_W >= N_TAPS.
- DATA_W, 16, signed sample width.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset; rst==0 at a rising edge resets the block.
- in_valid  in  1  source has a sample on in_data.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  DATA_W  signed input sample.
- wr_en  out  1  sample RAM write strobe.
- wr_addr  out  ADDR_W  sample RAM write address.
- wr_data  out  DATA_W  sample RAM write data.
- rd_addr  out  ADDR_W  sample RAM read address; the RAM has synchronous read with 1-cycle latency.
- coef_addr  out  ADDR_W  coefficient ROM address; the ROM has 1-cycle latency.
- mac_clr  out  1  with mac_en: MAC loads the product instead of accumulating.
- mac_en  out  1  MAC accumulates the RAM×ROM product this cycle; result is registered.
- out_valid  out  1  one-cycle strobe; the MAC accumulator holds y[n].
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst==0): state=INIT, head=0, init_cnt=0.
  - All outputs are 0: in_ready, wr_en, wr_addr, wr_data, rd_addr, coef_addr, mac_clr, mac_en, out_valid.
  - busy=1.
- Reset mid-operation aborts the current sample: no out_valid, and INIT restarts.
- INIT: clears the sample RAM.
  - Drives wr_en=1, wr_addr=init_cnt, wr_data=0 for init_cnt=0..N_TAPS-1 (exactly N_TAPS cycles).
  - Then goes to IDLE. in_ready=0 throughout.
- IDLE: in_ready=1, busy=0.
  - On in_valid&&in_ready (cycle T): capture in_data into an internal register, then go to WRITE.
- WRITE (T+1): wr_en=1, wr_addr=head, wr_data=captured sample. Then go to RUN with k=0, ra=head.
- RUN (T+2 .. T+N_TAPS+1): coef_addr=k, rd_addr=ra.
  - k increments each cycle.
  - ra decrements mod N_TAPS: 0 wraps to N_TAPS-1.
  - After k=N_TAPS-1, go to DRAIN.
- mac_en is RUN delayed by one cycle (asserted T+3 .. T+N_TAPS+2).
  - mac_clr=1 only on the first mac_en cycle (T+3).
- DRAIN (T+N_TAPS+2): last mac_en cycle; then go to DONE.
- DONE (T+N_TAPS+3): out_valid=1 for one cycle.
  - head <= (head==N_TAPS-1) ? 0 : head+1.
  - Next state is IDLE.
- Latency: accept to out_valid = N_TAPS+3 cycles.
  - Minimum accept-to-accept period = N_TAPS+4 cycles (127 at default).
- Read pointer: rd_addr at tap k is x[n-k], i.e. (head-k) mod N_TAPS. The read of head at T+2 follows the write at T+1 (write-before-read across cycles; no bypass needed).
- in_valid while not in IDLE is ignored (in_ready=0); in_data must be held by the source.
- Address outputs are registered, and hold their last value when not in use.
  - In IDLE they are not required to be 0 except after reset.
- The last coefficient address is N_TAPS-1, never N_TAPS.

Decomposition:
- Package fir_ctrl_pkg:
  - state encoding (INIT, IDLE, WRITE, RUN, DRAIN, DONE);
  - default N_TAPS/ADDR_W/DATA_W;
  - a wrap helper for modulo-N decrement/increment.
- Sub-module fir_circ_addr: loadable mod-N down/up counter with load, step and wrap.
  - Used for ra; a second instance is used for head.
  - Counts and write addresses for INIT come from a plain counter in the top.

Test Plan:
- Reset release, N_TAPS=4 -> wr_en=1 with wr_addr 0,1,2,3 and wr_data=0 on 4 consecutive cycles, then in_ready=1 and busy=0.
- One sample 100 accepted at T, N_TAPS=4 -> the following sequence, with nothing else asserted:
  - T+1: wr_addr=0, wr_data=100;
  - T+2..T+5: rd_addr 0,3,2,1 and coef_addr 0,1,2,3;
  - T+3..T+6: mac_en=1, with mac_clr only at T+3;
  - T+7: out_valid=1.
- Five back-to-back samples, N_TAPS=4 -> head wraps 0,1,2,3,0; the 5th sample writes addr 0 and reads 0,3,2,1; accepts are spaced exactly 8 cycles apart.
- in_valid held high continuously -> in_ready=1 only in IDLE, exactly one accept per 8 cycles, and no sample is lost or duplicated.
- rst=0 at T+4 mid-RUN -> next cycle state=INIT, all strobes 0, no out_valid; after N_TAPS INIT cycles, head=0.
- Default N_TAPS=123 with a golden MAC model and an impulse of 1 followed by zeros -> 123 outputs equal to coef[0..122], each out_valid 126 cycles after its accept.
